// File: rtl/perceptron_delta_engine_pkg.sv
// Shared constants and types for the perceptron backward (delta) path.
// The forward activation stage imports the same ONE / NEG_ONE constants so
// both directions clamp at exactly the same points.
//
// Contents:
//   DATA_W / ACC_W / PROD_W : Q2.14 sample, pre-activation and product widths
//   Q_ONESHIFT              : fractional bits of the Q2.14 format
//   ONE / NEG_ONE           : +1.0 / -1.0 at pre-activation width (48 bits)
//   state_e                 : delta engine FSM states
package perceptron_delta_engine_pkg;

  localparam int DATA_W     = 16;
  localparam int ACC_W      = 48;
  localparam int PROD_W     = 33;
  localparam int Q_ONESHIFT = 14;

  localparam logic signed [ACC_W-1:0] ONE     = 48'sd1 <<< Q_ONESHIFT;
  localparam logic signed [ACC_W-1:0] NEG_ONE = -ONE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELTA  = 2'd1,
    STREAM = 2'd2
  } state_e;

endpackage

// File: rtl/perceptron_delta_engine_sat_shift_q14.sv
// sat_shift_q14: combinational arithmetic right shift of a 33-bit signed
// product followed by saturation to the signed 16-bit Q2.14 range.
// The shift floors toward minus infinity (no rounding), matching the delta
// path; the weight-update adder instantiates the same block.
//
// Ports:
//   i_p : signed 33-bit product
//   o_q : signed 16-bit shifted and saturated result
module sat_shift_q14
  import perceptron_delta_engine_pkg::*;
#(
  parameter int SHIFT = 18
) (
  input  logic signed [PROD_W-1:0] i_p,
  output logic signed [DATA_W-1:0] o_q
);

  localparam logic signed [PROD_W-1:0] MAX_V = 33'sd32767;
  localparam logic signed [PROD_W-1:0] MIN_V = -33'sd32768;

  function automatic logic signed [DATA_W-1:0] sat_q14(
    input logic signed [PROD_W-1:0] v
  );
    logic signed [DATA_W-1:0] q;
    if (v > MAX_V) begin
      q = 16'sh7FFF;
    end else if (v < MIN_V) begin
      q = 16'sh8000;
    end else begin
      q = v[DATA_W-1:0];
    end
    return q;
  endfunction

  logic signed [PROD_W-1:0] w_shifted;

  assign w_shifted = i_p >>> SHIFT;
  assign o_q       = sat_q14(w_shifted);

endmodule

// File: rtl/perceptron_delta_engine.sv
// perceptron_delta_engine: backward path of the perceptron activation.
// Takes one sample's 48-bit pre-activation z and Q2.14 target, forms the
// hard-tanh error term (zero when the forward clamp saturated), then streams
// N_INPUTS Q2.14 inputs x and returns one saturated Q2.14 weight delta per x.
//
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_start_valid / o_start_ready  : sample handshake, captures i_z, i_target
//   i_z                            : signed 48-bit pre-activation
//   i_target                       : signed Q2.14 target
//   i_x_valid / o_x_ready, i_x     : input stream
//   o_dw_valid / i_dw_ready, o_dw  : delta stream, o_dw_last on the final one
//   o_busy                         : high whenever the FSM is not IDLE
module perceptron_delta_engine
  import perceptron_delta_engine_pkg::*;
#(
  parameter int N_INPUTS = 2,
  parameter int LR_SHIFT = 4,
  parameter int ONESHIFT = 14
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start_valid,
  output logic                     o_start_ready,
  input  logic signed [ACC_W-1:0]  i_z,
  input  logic signed [DATA_W-1:0] i_target,
  input  logic                     i_x_valid,
  output logic                     o_x_ready,
  input  logic signed [DATA_W-1:0] i_x,
  output logic                     o_dw_valid,
  input  logic                     i_dw_ready,
  output logic signed [DATA_W-1:0] o_dw,
  output logic                     o_dw_last,
  output logic                     o_busy
);

  localparam int IDX_W = (N_INPUTS < 1) ? 1 : $clog2(N_INPUTS + 1);
  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [IDX_W-1:0]         r_idx;

  logic signed [ACC_W-1:0]  r_z_p0;
  logic signed [DATA_W-1:0] r_target_p0;
  logic signed [DATA_W:0]   r_delta_p0;

  logic signed [DATA_W-1:0] r_dw_p1;
  logic                     r_vld_p1;
  logic                     r_last_p1;

  logic                     w_start_hs;
  logic                     w_x_hs;
  logic                     w_dw_hs;
  logic                     w_sat;
  logic signed [DATA_W-1:0] w_y;
  logic signed [DATA_W:0]   w_err;
  logic signed [DATA_W:0]   w_delta;
  logic signed [PROD_W-1:0] w_p;
  logic signed [DATA_W-1:0] w_dw;

  // ---- stage p0: hard-tanh clamp and error term (DELTA state) ----
  // Strict compares: |z| == ONE is inside the linear region, so the
  // derivative (and hence delta) stays nonzero there.
  always_comb begin
    w_sat = 1'b0;
    w_y   = r_z_p0[DATA_W-1:0];
    if (r_z_p0 > ONE) begin
      w_sat = 1'b1;
      w_y   = 16'sh4000;
    end else if (r_z_p0 < NEG_ONE) begin
      w_sat = 1'b1;
      w_y   = 16'shC000;
    end
  end

  assign w_err   = $signed({r_target_p0[DATA_W-1], r_target_p0})
                 - $signed({w_y[DATA_W-1], w_y});
  assign w_delta = w_sat ? '0 : w_err;

  // ---- stage p1: delta * x, renormalise + learning-rate shift, saturate ----
  assign w_p = $signed({{(PROD_W-DATA_W-1){r_delta_p0[DATA_W]}}, r_delta_p0})
             * $signed({{(PROD_W-DATA_W){i_x[DATA_W-1]}}, i_x});

  sat_shift_q14 #(
    .SHIFT(ONESHIFT + LR_SHIFT)
  ) u_sat_shift (
    .i_p(w_p),
    .o_q(w_dw)
  );

  // FSM next state and handshake readies
  always_comb begin
    w_state_nxt   = r_state;
    o_start_ready = 1'b0;
    o_x_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        o_start_ready = 1'b1;
        if (i_start_valid) w_state_nxt = DELTA;
      end
      DELTA: begin
        w_state_nxt = STREAM;
      end
      STREAM: begin
        // Single-entry output register: a new x may load in the same cycle
        // the held dw is popped.
        o_x_ready = (r_idx < N_IDX) && (!r_vld_p1 || i_dw_ready);
        if (r_vld_p1 && i_dw_ready && r_last_p1) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_start_hs = i_start_valid && o_start_ready;
  assign w_x_hs     = i_x_valid && o_x_ready;
  assign w_dw_hs    = r_vld_p1 && i_dw_ready;

  // Control and output register; reset discards any pending delta.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_dw_p1   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == DELTA) r_idx <= '0;
      if (w_x_hs) begin
        r_dw_p1   <= w_dw;
        r_vld_p1  <= 1'b1;
        r_last_p1 <= (r_idx == LAST_IDX);
        r_idx     <= r_idx + 1'b1;
      end else if (w_dw_hs) begin
        r_vld_p1  <= 1'b0;
        r_last_p1 <= 1'b0;
      end
    end
  end

  // Sample operands and the error term carry no reset; they are always
  // rewritten before use.
  always_ff @(posedge i_clk) begin
    if (w_start_hs) begin
      r_z_p0      <= i_z;
      r_target_p0 <= i_target;
    end
    if (r_state == DELTA) r_delta_p0 <= w_delta;
  end

  assign o_dw_valid = r_vld_p1;
  assign o_dw       = r_dw_p1;
  assign o_dw_last  = r_last_p1;
  assign o_busy     = (r_state != IDLE);

endmodule

// File: doc/perceptron_delta_engine.md
# perceptron_delta_engine

Backward-path counterpart of the perceptron's forward activation stage. It takes one training sample's 48-bit pre-activation accumulator and Q2.14 target. It forms the hard-tanh error term, then streams N Q2.14 inputs and returns N saturated Q2.14 weight deltas. The weight-update logic consumes the deltas through a valid/ready interface.

## Interface
- N_INPUTS, 2, number of x/dw pairs per sample (≥1)
- LR_SHIFT, 4, learning-rate right shift applied after the Q2.14 renormalise
- ONESHIFT, 14, fractional bits; ONE = 1<<ONESHIFT
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_valid / start_ready  in / out  1  sample handshake
- z  in  48  signed pre-activation, sampled on start handshake
- target  in  16  signed Q2.14 target, sampled on start handshake
- x_valid / x_ready  in / out  1  input-stream handshake
- x  in  16  signed Q2.14 input value
- dw_valid / dw_ready  out / in  1  delta-stream handshake
- dw  out  16  signed Q2.14 weight delta
- dw_last  out  1  marks delta N_INPUTS-1
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE → DELTA → STREAM → IDLE.
- IDLE: start_ready=1. When start_valid&&start_ready, register z and target, then go to DELTA.
- DELTA, one cycle. Compute the clamp with strict compares, identical to the forward path:
  - z > ONE → y=0x4000
  - z < -ONE → y=0xC000
  - otherwise y=z[15:0]
  - sat = either strict compare true
  - err = target − y, 17-bit signed
  - delta = sat ? 0 : err
  - Go to STREAM with idx=0.
- STREAM:
  - x_ready = (idx<N_INPUTS) && (!dw_valid || dw_ready). This is a single-entry output register with pass-through on pop.
  - On x handshake:
    - p = delta*x, 33-bit signed
    - s = p >>> (ONESHIFT+LR_SHIFT), arithmetic (floor)
    - dw = s saturated to [0x8000, 0x7FFF]
    - dw_valid=1; dw_last = (idx==N_INPUTS-1); idx++
  - When dw_valid&&dw_ready and no new x is loaded, clear dw_valid and dw_last.
  - After the handshake of the dw with dw_last=1, go to IDLE.
- start_valid outside IDLE is ignored; start_ready=0.
- x_valid outside STREAM is ignored; x_ready=0.
- Saturation at exactly |z|==ONE is false, so delta is nonzero there. This matches the forward derivative convention.
- rst_n low at any time, including mid-stream:
  - Go immediately to IDLE and clear idx.
  - Discard the pending dw.
  - No partial sample resumes.

## Timing
- Reset values: dw_valid=0, dw=0, dw_last=0, x_ready=0, busy=0, start_ready=1 (state IDLE), idx=0.
- Start handshake at cycle T: DELTA at T+1, x_ready may assert at T+2.
- x accepted at cycle C → dw_valid high at C+1. Latency is 1 cycle.
- With dw_ready held high, throughput is 1 dw per cycle. A full sample takes N_INPUTS+2 cycles of busy after start.
- With dw_ready low, dw, dw_last and dw_valid hold stable and x_ready is 0.
- Final dw handshake at cycle L → state IDLE and start_ready=1 at L+1.

## Structure
- Shared package holds:
  - Q2.14 width and ONESHIFT constants
  - ONE / NEG_ONE, 48-bit
  - the state enum {IDLE, DELTA, STREAM}
- The forward activation stage imports the same ONE constants from this package.
- Sub-module sat_shift_q14: combinational 33-bit arithmetic shift plus 16-bit saturate. It is parameterised by shift amount and reused by the weight-update adder.

## Test plan
- z=0x2000, target=0x4000, x=0x4000,0xC000 (defaults) → dw=0x0200 then 0xFE00, dw_last on second only, then IDLE.
- z=0x8000 (2.0), target=0x0000, x=0x4000,0x4000 → delta=0, dw=0x0000,0x0000; z=−0x8000 gives the same.
- z=0x4000 exactly, target=0, x=0x4000 → not saturated, err=−0x4000, dw=0xFC00.
- LR_SHIFT=0, z=−0x4000, target=0x7FFF, x=0x7FFF then 0x8000:
  - err=49151
  - dw=0x7FFF (positive saturation), then 0x8000 (negative saturation).
- dw_ready low 3 cycles after first dw → dw stable, x_ready=0, no x consumed; resumes correctly when dw_ready rises.
- rst_n pulse after first dw of a 2-input sample → outputs at reset values; new start accepted next cycle; stale x not emitted.
